// File: rtl/cflib_rstseq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cflib_rstseq_pkg
// Purpose  : Shared types and helpers for the reset sequencer (rstseq).
//            - rstseq_state_t : 2-bit sequencer state encoding
//            - cnt_width()    : spacing/hold counter width from DELAY and HOLD
//            - idx_width()    : domain index width from NDOMAINS
// Revision : 1.0 - initial release
// ============================================================================
package cflib_rstseq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,  // all domains asserted, waiting out the hold time
    ST_RELEASE = 2'd1,  // releasing domains one by one, DELAY apart
    ST_RUN     = 2'd2,  // all domains released
    ST_ASSERT  = 2'd3   // re-asserting domains, highest index first
  } rstseq_state_t;

  // Counter must reach max(DELAY,HOLD)-1; never narrower than one bit.
  function automatic int cnt_width(input int delay, input int hold);
    int m;
    int w;
    m = (delay > hold) ? delay : hold;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

  // Index must reach NDOMAINS-1; never narrower than one bit.
  function automatic int idx_width(input int ndomains);
    int w;
    w = $clog2(ndomains);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rstseq.sv
`default_nettype none
// ============================================================================
// Module   : rstseq
// Purpose  : Reset sequencer. After a minimum hold time, releases NDOMAINS
//            active-low domain resets one after another, DELAY cycles apart.
//            A software request in RUN re-asserts the domains in reverse
//            order (one per cycle) and then replays the release sequence.
// Ports    : clock      - system clock, rising edge
//            aresetn    - async active-low reset (release already synchronous)
//            swreq      - software re-reset request, honoured only in RUN
//            resetn_out - per-domain active-low resets, straight from flops
//            ready      - high exactly while in RUN (all domains released)
// Revision : 1.0 - initial release
// ============================================================================
module rstseq
  import cflib_rstseq_pkg::*;
#(
  parameter int NDOMAINS = 4,
  parameter int DELAY    = 16,
  parameter int HOLD     = 8
) (
  input  logic                clock,
  input  logic                aresetn,
  input  logic                swreq,
  output logic [NDOMAINS-1:0] resetn_out,
  output logic                ready
);

  localparam int c_cnt_w = cnt_width(DELAY, HOLD);
  localparam int c_idx_w = idx_width(NDOMAINS);

  localparam logic [c_cnt_w-1:0] c_hold_last  = c_cnt_w'(HOLD - 1);
  localparam logic [c_cnt_w-1:0] c_delay_last = c_cnt_w'(DELAY - 1);
  localparam logic [c_idx_w-1:0] c_idx_last   = c_idx_w'(NDOMAINS - 1);
  // Starting index of the reverse walk; the top domain is cleared on the
  // RUN->ASSERT edge itself, so the walk begins one below it.
  localparam logic [c_idx_w-1:0] c_idx_penult = c_idx_w'((NDOMAINS > 1) ? NDOMAINS - 2 : 0);

  rstseq_state_t       r_state;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_idx_w-1:0]  r_idx;
  logic [NDOMAINS-1:0] r_resetn;
  logic                r_ready;

  rstseq_state_t       w_state;
  logic [c_cnt_w-1:0]  w_cnt;
  logic [c_idx_w-1:0]  w_idx;
  logic [NDOMAINS-1:0] w_resetn;
  logic                w_ready;

  // --------------------------------------------------------------------------
  // State register. Every output is a flop so the domain resets cannot glitch.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= ST_HOLD;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_resetn <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_idx    <= w_idx;
      r_resetn <= w_resetn;
      r_ready  <= w_ready;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_idx    = r_idx;
    w_resetn = r_resetn;
    w_ready  = r_ready;

    case (r_state)
      ST_HOLD: begin
        if (r_cnt == c_hold_last) begin
          w_cnt   = '0;
          w_idx   = '0;
          w_state = ST_RELEASE;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      ST_RELEASE: begin
        if (r_cnt == c_delay_last) begin
          w_cnt           = '0;
          w_resetn[r_idx] = 1'b1;
          w_idx           = r_idx + 1'b1;
          // Last domain and ready rise on the same edge.
          if (r_idx == c_idx_last) begin
            w_state = ST_RUN;
            w_ready = 1'b1;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      ST_RUN: begin
        if (swreq) begin
          w_ready              = 1'b0;
          w_resetn[NDOMAINS-1] = 1'b0;
          if (NDOMAINS == 1) begin
            // Only one domain: it is already asserted, go straight to hold.
            w_state = ST_HOLD;
            w_cnt   = '0;
          end else begin
            w_idx   = c_idx_penult;
            w_state = ST_ASSERT;
          end
        end
      end

      ST_ASSERT: begin
        // One domain per cycle, no spacing on assertion.
        w_resetn[r_idx] = 1'b0;
        if (r_idx == '0) begin
          w_state = ST_HOLD;
          w_cnt   = '0;
        end else begin
          w_idx = r_idx - 1'b1;
        end
      end

      default: begin
        w_state = ST_HOLD;
      end
    endcase
  end

  assign resetn_out = r_resetn;
  assign ready      = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_rstseq.sv
`default_nettype none
// ============================================================================
// Module   : tb_rstseq
// Purpose  : Self-checking bench for rstseq. Two instances share clock and
//            reset: a 4-domain (DELAY=16, HOLD=8) and a 1-domain (DELAY=1,
//            HOLD=1) configuration. A timeline model predicts outputs from
//            the number of edges since the sequence started.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rstseq;

  logic       clock = 1'b0;
  logic       aresetn;
  logic       swreq4;
  logic       swreq1;
  logic [3:0] rout4;
  logic       rdy4;
  logic [0:0] rout1;
  logic       rdy1;

  always #5 clock = ~clock;

  rstseq #(.NDOMAINS(4), .DELAY(16), .HOLD(8)) u_dut4 (
    .clock      (clock),
    .aresetn    (aresetn),
    .swreq      (swreq4),
    .resetn_out (rout4),
    .ready      (rdy4)
  );

  rstseq #(.NDOMAINS(1), .DELAY(1), .HOLD(1)) u_dut1 (
    .clock      (clock),
    .aresetn    (aresetn),
    .swreq      (swreq1),
    .resetn_out (rout1),
    .ready      (rdy1)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model. mode 0 = sequencing (e edges since start), 1 = running,
  // 2 = re-asserting with lvl domains still high.
  // --------------------------------------------------------------------------
  int m_n[2] = '{4, 1};
  int m_d[2] = '{16, 1};
  int m_h[2] = '{8, 1};
  int mode[2];
  int e[2];
  int lvl[2];

  // Domain k is high after edge HOLD + (k+1)*DELAY.
  function automatic int released(input int m);
    int c;
    if (e[m] < m_h[m]) return 0;
    c = (e[m] - m_h[m]) / m_d[m];
    return (c > m_n[m]) ? m_n[m] : c;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mode[m] = 0;
      e[m]    = 0;
      lvl[m]  = 0;
    end
  endtask

  task automatic model_step(input int m, input logic sw);
    case (mode[m])
      0: begin
        e[m]++;
        if (released(m) == m_n[m]) mode[m] = 1;
      end
      1: begin
        if (sw) begin
          lvl[m] = m_n[m] - 1;
          if (lvl[m] == 0) begin
            mode[m] = 0;
            e[m]    = 0;
          end else begin
            mode[m] = 2;
          end
        end
      end
      default: begin
        lvl[m]--;
        if (lvl[m] == 0) begin
          mode[m] = 0;
          e[m]    = 0;
        end
      end
    endcase
  endtask

  function automatic logic [31:0] exp_out(input int m);
    case (mode[m])
      0:       return (32'd1 << released(m)) - 32'd1;
      1:       return (32'd1 << m_n[m]) - 32'd1;
      default: return (32'd1 << lvl[m]) - 32'd1;
    endcase
  endfunction

  function automatic logic [31:0] exp_rdy(input int m);
    return (mode[m] == 1) ? 32'd1 : 32'd0;
  endfunction

  task automatic check_all();
    chk("out4", {28'd0, rout4}, exp_out(0));
    chk("rdy4", {31'd0, rdy4},  exp_rdy(0));
    chk("out1", {31'd0, rout1}, exp_out(1));
    chk("rdy1", {31'd0, rdy1},  exp_rdy(1));
  endtask

  function automatic logic pick(input int p);
    case (p)
      0:       return 1'b0;
      1:       return ($urandom_range(0, 59) == 0);
      2:       return ($urandom_range(0, 2) == 0);
      3:       return 1'b1;
      default: return ($urandom_range(0, 39) == 0);
    endcase
  endfunction

  // Async reset mid-cycle: outputs must drop with no clock edge, stay low
  // while held, and the full sequence restarts after release.
  task automatic async_reset();
    #2 aresetn = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) begin
      @(posedge clock);
      #1;
      check_all();
    end
    #1 aresetn = 1'b1;
  endtask

  task automatic cycle(input int p);
    @(negedge clock);
    swreq4 = pick(p);
    swreq1 = pick(p);
    @(posedge clock);
    #1;
    model_step(0, swreq4);
    model_step(1, swreq1);
    check_all();
    if (p == 4 && $urandom_range(0, 149) == 0) async_reset();
  endtask

  int phase_len[5] = '{300, 1500, 800, 600, 2000};

  initial begin
    swreq4  = 1'b0;
    swreq1  = 1'b0;
    aresetn = 1'b1;
    model_reset();
    #2 aresetn = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1;
      check_all();
    end
    #1 aresetn = 1'b1;

    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < phase_len[p]; i++) cycle(p);
    end

    // Deterministic mid-release reset, then a clean sequence from scratch.
    async_reset();
    for (int i = 0; i < 120; i++) cycle(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rstseq.md
Name: rstseq

Overview:
Reset sequencer, directly downstream of the reset synchronizer.
- Its async active-low reset is driven by the inverted synchronized reset (synchronous release), so it starts in a clean clock-aligned state.
- It releases NDOMAINS active-low domain resets one after another, with a programmable spacing, after a minimum hold time.
- It supports a software-requested re-reset that re-asserts the domains in reverse order, then replays the release sequence.

Parameters:
NDOMAINS, 4, number of sequenced reset domains (>=1); domain 0 is released first.
DELAY, 16, clock cycles between consecutive domain releases (>=1).
HOLD, 8, minimum clock cycles all domains stay asserted before the release sequence starts (>=1).

Ports:
clock  input  1  system clock; all state on rising edge
aresetn  input  1  asynchronous active-low reset; assertion is async, deassertion is already synchronous to clock
swreq  input  1  synchronous software re-reset request, sampled only in RUN
resetn_out  output  NDOMAINS  per-domain active-low resets, registered
ready  output  1  high when all domains are released and the block is in RUN

Behaviour:
- Reset (aresetn low, async): resetn_out = all 0, ready = 0, state = HOLD, cnt = 0, idx = 0.
- Counter width: $clog2(max(DELAY,HOLD)); minimum 1 bit. idx width: $clog2(NDOMAINS); minimum 1 bit.
- States: HOLD, RELEASE, RUN, ASSERT; the enum is 2 bits.
- HOLD: cnt increments each edge. On the edge where cnt == HOLD-1: cnt <= 0, idx <= 0, state <= RELEASE.
- RELEASE: cnt increments each edge. On the edge where cnt == DELAY-1:
  - cnt <= 0, resetn_out[idx] <= 1, idx <= idx+1.
  - If idx == NDOMAINS-1: state <= RUN and ready <= 1 on that same edge.
- Timing after reset release: counting edges from the first edge after aresetn deasserts as edge 1,
  - domain k goes high after edge HOLD + (k+1)*DELAY;
  - ready rises together with the last domain.
- RUN: outputs hold. swreq high on an edge:
  - ready <= 0, resetn_out[NDOMAINS-1] <= 0.
  - If NDOMAINS == 1: state <= HOLD, cnt <= 0.
  - Otherwise: idx <= NDOMAINS-2, state <= ASSERT.
- ASSERT: each edge clears resetn_out[idx].
  - If idx == 0: state <= HOLD, cnt <= 0.
  - Else: idx <= idx-1.
  - No DELAY spacing applies on assertion: one domain per cycle, highest index first.
- swreq outside RUN is ignored: no latching, no queueing. swreq held high continuously in RUN triggers again each time RUN is re-entered.
- DELAY == 1: domains are released on consecutive edges.
- aresetn asserted mid-sequence (any state): all outputs go low immediately (async), and the full sequence restarts from HOLD on release.
- ready == 1 exactly when state == RUN. resetn_out in RUN is always all ones.
- Glitch-free: every output comes directly from a flop; no combinational outputs.

Decomposition:
- Shared package cflib_rstseq_pkg holds:
  - the state enum typedef (HOLD, RELEASE, RUN, ASSERT);
  - a constant function computing the counter width from DELAY/HOLD.
- No sub-module inside the block. The integration level instantiates the reset synchronizer upstream and drives aresetn from it.
- A generic counter is not split out; cnt is inline, about 150 lines total.

Test Plan (NDOMAINS=4, DELAY=16, HOLD=8 unless stated):
1. Release aresetn, count edges -> resetn_out becomes 4'b0001 after edge 24, 4'b0011 after 40, 4'b0111 after 56, 4'b1111 after 72. ready rises after edge 72, not before.
2. In RUN, pulse swreq for 1 cycle at edge E -> 4'b0111 at E, 4'b0011 at E+1, 4'b0001 at E+2, 4'b0000 at E+3. ready low from E. Domain 0 high again after E+3+8+16 = E+27, 4'b1111 and ready after E+75.
3. Pulse swreq during RELEASE (e.g. edge 30) and during ASSERT -> no effect; sequence timing is identical to scenario 1 or 2.
4. Assert aresetn low at edge 45 (mid-RELEASE, mid-clock) -> resetn_out = 0 and ready = 0 immediately, without a clock edge. After release, the scenario 1 timing repeats from edge 1.
5. NDOMAINS=1, DELAY=1, HOLD=1:
   - release reset -> resetn_out = 1 and ready = 1 after edge 2;
   - swreq -> resetn_out = 0 at that edge, and 1 again 2 edges later.
6. Hold swreq high permanently -> after every RUN entry, re-reset starts on the next edge. ready is high for exactly one cycle per loop, and the loop period is constant.
